// File: rtl/ir_tx_sfr.sv
// NEC infrared transmitter on the 8051 SFR bus: firmware loads TXADDR/TXCMD,
// writes start, and the block serialises leader, addr, ~addr, cmd, ~cmd, stop.
// Ports: clk (registers update on falling edge), reset (async, active high),
//   addr/D_IN/sfr_wr/sfr_rd SFR bus in, D_OUT registered read data,
//   ir_tx LED drive (active high), tx_busy frame in flight.
// Build option: define IR_TX_CARRIER_EN to gate ir_tx with the ~38 kHz
//   carrier; left undefined, ir_tx is the baseband envelope.
module ir_tx_sfr #(
  parameter int unsigned TICK_CYCLES  = 28125,
  parameter int unsigned CARRIER_HALF = 658
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] addr,
  input  logic [7:0] D_IN,
  input  logic       sfr_wr,
  input  logic       sfr_rd,
  output logic [7:0] D_OUT,
  output logic       ir_tx,
  output logic       tx_busy
);

  localparam int unsigned CW = $clog2(16 * TICK_CYCLES) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD_MARK,
    S_LEAD_SPACE,
    S_BIT_MARK,
    S_BIT_SPACE,
    S_STOP_MARK
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    bit_q, bit_d;
  logic [31:0]   sh_q, sh_d;
  logic [7:0]    txaddr_q, txaddr_d;
  logic [7:0]    txcmd_q, txcmd_d;
  logic [7:0]    dout_q, dout_d;
  logic          done_q, done_d;
  logic          pend_q, pend_d;
  logic          ir_tx_q, ir_tx_d;

  logic          sel_addr, sel_cmd, sel_ctl;
  logic          busy, busy_d, start_acc, done_set, mark_d;
  int unsigned   dur;
  logic [CW-1:0] last_cyc;

  assign sel_addr  = (addr == 8'hE1);
  assign sel_cmd   = (addr == 8'hE2);
  assign sel_ctl   = (addr == 8'hE3);

  // pend_q covers the one cycle between the start write and the leader,
  // so busy is visible at once while the envelope rises one edge later.
  assign busy      = pend_q | (state_q != S_IDLE);
  assign start_acc = sfr_wr & sel_ctl & D_IN[0] & ~busy;

  assign tx_busy   = busy;
  assign ir_tx     = ir_tx_q;
  assign D_OUT     = dout_q;

  always_comb begin
    dur = 1;
    unique case (state_q)
      S_LEAD_MARK:  dur = 16;
      S_LEAD_SPACE: dur = 8;
      S_BIT_SPACE:  dur = sh_q[0] ? 3 : 1;
      default:      dur = 1;
    endcase
    last_cyc = CW'(dur * TICK_CYCLES - 1);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    sh_d     = sh_q;
    done_set = 1'b0;
    pend_d   = start_acc;
    if (start_acc)
      sh_d = {~txcmd_q, txcmd_q, ~txaddr_q, txaddr_q};
    if (state_q == S_IDLE) begin
      if (pend_q) begin
        state_d = S_LEAD_MARK;
        cnt_d   = '0;
      end
    end else if (cnt_q != last_cyc) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = '0;
      unique case (state_q)
        S_LEAD_MARK:  state_d = S_LEAD_SPACE;
        S_LEAD_SPACE: begin
          state_d = S_BIT_MARK;
          bit_d   = 5'd0;
        end
        S_BIT_MARK:   state_d = S_BIT_SPACE;
        S_BIT_SPACE:  begin
          sh_d = {1'b0, sh_q[31:1]};
          if (bit_q == 5'd31) begin
            state_d = S_STOP_MARK;
          end else begin
            state_d = S_BIT_MARK;
            bit_d   = bit_q + 5'd1;
          end
        end
        S_STOP_MARK:  begin
          state_d  = S_IDLE;
          done_set = 1'b1;
        end
        default:      state_d = S_IDLE;
      endcase
    end
  end

  assign busy_d = pend_d | (state_d != S_IDLE);
  assign mark_d = (state_d == S_LEAD_MARK) |
                  (state_d == S_BIT_MARK) |
                  (state_d == S_STOP_MARK);

`ifdef IR_TX_CARRIER_EN
  localparam int unsigned HW =
    (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;

  logic [HW-1:0] car_q, car_d;
  logic          ph_q, ph_d;

  // Restart the carrier on every mark entry so each burst opens high.
  always_comb begin
    car_d = car_q;
    ph_d  = ph_q;
    if (mark_d && (state_d != state_q)) begin
      car_d = '0;
      ph_d  = 1'b1;
    end else if (mark_d) begin
      if (car_q == HW'(CARRIER_HALF - 1)) begin
        car_d = '0;
        ph_d  = ~ph_q;
      end else begin
        car_d = car_q + HW'(1);
      end
    end
  end

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      car_q <= '0;
      ph_q  <= 1'b0;
    end else begin
      car_q <= car_d;
      ph_q  <= ph_d;
    end
  end

  assign ir_tx_d = mark_d & ph_d;
`else
  assign ir_tx_d = mark_d;
`endif

  always_comb begin
    txaddr_d = (sfr_wr && sel_addr) ? D_IN : txaddr_q;
    txcmd_d  = (sfr_wr && sel_cmd)  ? D_IN : txcmd_q;
    done_d   = done_q | done_set;
    if ((sfr_rd && sel_ctl) || start_acc)
      done_d = 1'b0;
    dout_d = dout_q;
    if (sfr_rd) begin
      unique case (1'b1)
        sel_addr: dout_d = txaddr_q;
        sel_cmd:  dout_d = txcmd_q;
        // A done bit set this same cycle is still reported.
        sel_ctl:  dout_d = {6'b0, done_q | done_set, busy_d};
        default:  dout_d = dout_q;
      endcase
    end
  end

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      sh_q     <= '0;
      txaddr_q <= '0;
      txcmd_q  <= '0;
      dout_q   <= '0;
      done_q   <= 1'b0;
      pend_q   <= 1'b0;
      ir_tx_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      txaddr_q <= txaddr_d;
      txcmd_q  <= txcmd_d;
      dout_q   <= dout_d;
      done_q   <= done_d;
      pend_q   <= pend_d;
      ir_tx_q  <= ir_tx_d;
    end
  end

endmodule

// File: tb/tb_ir_tx_sfr.sv
// Bench for ir_tx_sfr: random SFR traffic against a frame/status model,
// with a scoreboard checking D_OUT reads and every transmitted frame.
module tb_ir_tx_sfr;

  localparam int T     = 4;
  localparam int CH    = 2;
  localparam int FRAME = 121 * T;

  logic       clk = 0;
  logic       reset = 1;
  logic [7:0] addr = 0;
  logic [7:0] D_IN = 0;
  logic       sfr_wr = 0;
  logic       sfr_rd = 0;
  logic [7:0] D_OUT;
  logic       ir_tx;
  logic       tx_busy;

  ir_tx_sfr #(.TICK_CYCLES(T), .CARRIER_HALF(CH)) dut (
    .clk    (clk),
    .reset  (reset),
    .addr   (addr),
    .D_IN   (D_IN),
    .sfr_wr (sfr_wr),
    .sfr_rd (sfr_rd),
    .D_OUT  (D_OUT),
    .ir_tx  (ir_tx),
    .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(negedge clk) edge_n++;

  int checks = 0;
  int errors = 0;

  logic [7:0]  rd_q[$];
  logic [31:0] frame_q[$];
  bit          exp_w[$];
  bit          mon_en = 1;
  int          starts = 0;
  int          frames_seen = 0;

  // ---------------- reference model ----------------
  logic [7:0] m_addr = 0, m_cmd = 0, dout_m = 0;
  bit         done_m = 0, f_active = 0;
  int         fend = -100;

  function automatic void add_seg(input bit m, input int ticks);
    for (int k = 0; k < ticks * T; k++) begin
`ifdef IR_TX_CARRIER_EN
      exp_w.push_back(m && ((k / CH) % 2 == 0));
`else
      exp_w.push_back(m);
`endif
    end
  endfunction

  function automatic void build(input logic [31:0] d);
    exp_w.delete();
    add_seg(1, 16);
    add_seg(0, 8);
    for (int i = 0; i < 32; i++) begin
      add_seg(1, 1);
      add_seg(0, d[i] ? 3 : 1);
    end
    add_seg(1, 1);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic upd(input int e);
    if (f_active && e >= fend) begin
      f_active = 0;
      done_m   = 1;
    end
  endtask

  task automatic idle1();
    @(posedge clk);
    sfr_wr = 0;
    sfr_rd = 0;
  endtask

  task automatic idle_until(input int target);
    while (edge_n + 2 < target) idle1();
  endtask

  task automatic bus_wr(input logic [7:0] a, input logic [7:0] d);
    int e;
    @(posedge clk);
    e = edge_n + 1;
    upd(e);
    addr = a; D_IN = d; sfr_wr = 1; sfr_rd = 0;
    if (a == 8'hE1) m_addr = d;
    else if (a == 8'hE2) m_cmd = d;
    else if (a == 8'hE3 && d[0] && e > fend) begin
      frame_q.push_back({~m_cmd, m_cmd, ~m_addr, m_addr});
      fend     = e + 1 + FRAME;
      f_active = 1;
      done_m   = 0;
      starts++;
    end
  endtask

  task automatic bus_rd(input logic [7:0] a);
    int e;
    @(posedge clk);
    e = edge_n + 1;
    upd(e);
    addr = a; D_IN = 0; sfr_wr = 0; sfr_rd = 1;
    if (a == 8'hE1) dout_m = m_addr;
    else if (a == 8'hE2) dout_m = m_cmd;
    else if (a == 8'hE3) begin
      dout_m = {6'b0, done_m, f_active};
      done_m = 0;
    end
    rd_q.push_back(dout_m);
  endtask

  // ---------------- read monitor ----------------
  logic       rd_seen = 0;
  logic [7:0] exp_b;
  always @(negedge clk) rd_seen <= sfr_rd & ~reset;

  always @(posedge clk) begin
    if (rd_seen) begin
      checks++;
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL rd_extra: D_OUT=%02h with nothing expected", D_OUT);
      end else begin
        exp_b = rd_q.pop_front();
        if (D_OUT !== exp_b) begin
          errors++;
          $display("FAIL rd_data: D_OUT=%02h expected %02h", D_OUT, exp_b);
        end
      end
    end
  end

  // ---------------- frame monitor ----------------
  bit in_frame = 0;
  bit busy_prev = 0;
  int idx = 0;
  int fr_err = 0;

  always @(posedge clk) begin
    if (reset) begin
      in_frame = 0;
    end else if (!in_frame) begin
      if (tx_busy && !busy_prev && mon_en) begin
        checks++;
        if (frame_q.size() == 0) begin
          errors++;
          $display("FAIL frame_extra: busy rose with no frame expected");
        end else begin
          build(frame_q.pop_front());
          frames_seen++;
          in_frame = 1;
          idx      = 0;
          fr_err   = 0;
          if (ir_tx !== 1'b0) begin
            errors++;
            $display("FAIL frame_early: ir_tx=%b on start edge, want 0", ir_tx);
          end
        end
      end
    end else if (idx < FRAME) begin
      if (ir_tx !== exp_w[idx] || tx_busy !== 1'b1) begin
        if (fr_err == 0)
          $display("FAIL frame_wave: cycle %0d ir_tx=%b busy=%b want %b/1",
                   idx, ir_tx, tx_busy, exp_w[idx]);
        fr_err++;
      end
      idx++;
    end else begin
      checks += 2;
      if (fr_err != 0) errors++;
      if (tx_busy !== 1'b0 || ir_tx !== 1'b0) begin
        errors++;
        $display("FAIL frame_end: busy=%b ir_tx=%b after %0d cycles, want 0/0",
                 tx_busy, ir_tx, FRAME);
      end
      in_frame = 0;
    end
    busy_prev = tx_busy;
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(posedge clk);
    chk("rst_ir_tx", ir_tx, 0);
    chk("rst_busy", tx_busy, 0);
    chk("rst_dout", D_OUT, 0);
    reset = 0;

    bus_rd(8'hE1);
    bus_rd(8'hE2);
    bus_rd(8'hE3);

    bus_wr(8'hE1, 8'hA5);
    bus_wr(8'hE2, 8'h3C);
    bus_rd(8'hE1);
    bus_rd(8'hE2);
    bus_rd(8'hE4);
    bus_wr(8'hE3, 8'hFE);
    bus_rd(8'hE3);

    // Directed frame, then start-while-busy with a new address.
    bus_wr(8'hE1, 8'h00);
    bus_wr(8'hE2, 8'hFF);
    bus_wr(8'hE3, 8'h01);
    repeat (20) idle1();
    bus_rd(8'hE3);
    bus_wr(8'hE1, 8'h5A);
    bus_wr(8'hE3, 8'h01);
    bus_rd(8'hE3);
    idle_until(fend + 3);
    bus_rd(8'hE3);
    bus_rd(8'hE3);
    bus_wr(8'hE3, 8'h01);
    idle_until(fend);
    bus_rd(8'hE3);
    bus_rd(8'hE3);

    for (int f = 0; f < 5; f++) begin
      bus_wr(8'hE1, 8'($urandom));
      bus_wr(8'hE2, 8'($urandom));
      bus_wr(8'hE3, 8'($urandom) | 8'h01);
      for (int j = 0; j < 300 && edge_n < fend + 2; j++) begin
        case ($urandom_range(0, 6))
          0: bus_rd(8'(8'hE1 + $urandom_range(0, 3)));
          1: bus_wr(8'hE1, 8'($urandom));
          2: bus_wr(8'hE2, 8'($urandom));
          3: bus_wr(8'hE3, 8'($urandom) | 8'h01);
          4: bus_wr(8'hE3, 8'($urandom) & 8'hFE);
          default: repeat ($urandom_range(1, 40)) idle1();
        endcase
      end
      idle_until(fend + 2);
      bus_rd(8'hE3);
      bus_rd(8'hE3);
      bus_rd(8'hE1);
    end

    // Abort a frame with reset part-way through the leader.
    idle_until(fend + 4);
    repeat (3) idle1();
    mon_en = 0;
    @(posedge clk);
    addr = 8'hE3; D_IN = 8'h01; sfr_wr = 1; sfr_rd = 0;
    idle1();
    repeat (30) idle1();
    chk("pre_rst_busy", tx_busy, 1);
    #2 reset = 1;
    #1;
    chk("mid_rst_ir_tx", ir_tx, 0);
    chk("mid_rst_busy", tx_busy, 0);
    chk("mid_rst_dout", D_OUT, 0);
    @(posedge clk);
    reset = 0;
    m_addr = 0; m_cmd = 0; dout_m = 0;
    done_m = 0; f_active = 0; fend = -100;
    mon_en = 1;
    bus_rd(8'hE3);
    bus_rd(8'hE1);
    repeat (4) idle1();

    chk("rd_q_empty", rd_q.size(), 0);
    chk("frame_q_empty", frame_q.size(), 0);
    chk("frame_count", frames_seen, starts);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
